// File: rtl/si_div_if.sv
// si_div_if: request/result bundle for the sign-magnitude divider.
//   START       - request strobe, sampled only while the divider is idle
//   A, B        - dividend / divisor, sign-magnitude (MSB = sign)
//   BUSY        - divider is not idle
//   DONE        - one-cycle pulse, results valid
//   A_DIV_B     - quotient, sign-magnitude
//   A_MOD_B     - remainder, sign-magnitude
//   DIV_BY_ZERO - last accepted divisor had zero magnitude
// master: requester side, slave: divider side.
interface si_div_if #(
    parameter int unsigned N = 8
) ();
    logic         START;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] A_DIV_B;
    logic [N-1:0] A_MOD_B;
    logic         DIV_BY_ZERO;

    modport master (
        output START, A, B,
        input  BUSY, DONE, A_DIV_B, A_MOD_B, DIV_BY_ZERO
    );

    modport slave (
        input  START, A, B,
        output BUSY, DONE, A_DIV_B, A_MOD_B, DIV_BY_ZERO
    );
endinterface

// File: rtl/si_div.sv
// si_div: sequential sign-magnitude divider, restoring shift-subtract, one
// quotient magnitude bit per clock (N-1 iterations).
// Ports:
//   CLK - clock, rising edge
//   RST - asynchronous active-high reset
//   bus - si_div_if slave modport (START/A/B in, BUSY/DONE/results out)
// Build option: define SI_DIV_ZERO_NORM_EN to force the sign of any zero
// magnitude result to 0 (no negative zero). Latency is the same either way.
module si_div #(
    parameter int unsigned N = 8
) (
    input  logic  CLK,
    input  logic  RST,
    si_div_if.slave bus
);
    localparam int unsigned M  = N - 1;          // magnitude width
    localparam int unsigned CW = $clog2(N - 1);  // holds N-2

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [M-1:0]  r_rem, w_rem_nxt;     // partial remainder
    logic [M-1:0]  r_dvd, w_dvd_nxt;     // dividend bits out, quotient bits in
    logic [M-1:0]  r_bmag, w_bmag_nxt;
    logic          r_sb, w_sb_nxt;
    logic [N-1:0]  r_a, w_a_nxt;         // full dividend, needed for the /0 result
    logic [N-1:0]  r_quo, w_quo_nxt;
    logic [N-1:0]  r_mod, w_mod_nxt;
    logic          r_dbz, w_dbz_nxt;

    logic [M:0]    w_shift;
    logic [M:0]    w_diff;
    logic          w_qbit;
    logic [M-1:0]  w_rem_step;
    logic          w_sq;

    function automatic logic [N-1:0] f_fmt(input logic sgn, input logic [M-1:0] mag);
`ifdef SI_DIV_ZERO_NORM_EN
        return {sgn & (|mag), mag};
`else
        return {sgn, mag};
`endif
    endfunction

    // One restoring step. Both the shifted-in value (when below |B|) and the
    // difference (when not) are < |B|, so the new remainder fits in M bits.
    always_comb begin
        w_shift    = {r_rem, r_dvd[M-1]};
        w_diff     = w_shift - {1'b0, r_bmag};
        w_qbit     = (w_shift >= {1'b0, r_bmag});
        w_rem_step = w_qbit ? w_diff[M-1:0] : w_shift[M-1:0];
        w_sq       = r_a[N-1] ^ r_sb;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_dvd_nxt   = r_dvd;
        w_bmag_nxt  = r_bmag;
        w_sb_nxt    = r_sb;
        w_a_nxt     = r_a;
        w_quo_nxt   = r_quo;
        w_mod_nxt   = r_mod;
        w_dbz_nxt   = r_dbz;

        unique case (r_state)
            StIdle: begin
                if (bus.START) begin
                    w_a_nxt     = bus.A;
                    w_dvd_nxt   = bus.A[M-1:0];
                    w_bmag_nxt  = bus.B[M-1:0];
                    w_sb_nxt    = bus.B[N-1];
                    w_rem_nxt   = '0;
                    w_cnt_nxt   = CW'(N - 2);
                    w_dbz_nxt   = 1'b0;
                    w_state_nxt = StCalc;
                end
            end
            StCalc: begin
                if (r_bmag == '0) begin
                    // Zero divisor spends a single cycle here so DONE lands
                    // one cycle after the accepted START.
                    w_quo_nxt   = f_fmt(w_sq, {M{1'b1}});
                    w_mod_nxt   = f_fmt(r_a[N-1], r_a[M-1:0]);
                    w_dbz_nxt   = 1'b1;
                    w_state_nxt = StDone;
                end else begin
                    w_rem_nxt = w_rem_step;
                    w_dvd_nxt = {r_dvd[M-2:0], w_qbit};
                    if (r_cnt == '0) begin
                        w_quo_nxt   = f_fmt(w_sq, {r_dvd[M-2:0], w_qbit});
                        w_mod_nxt   = f_fmt(r_a[N-1], w_rem_step);
                        w_state_nxt = StDone;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_bmag  <= '0;
            r_sb    <= 1'b0;
            r_a     <= '0;
            r_quo   <= '0;
            r_mod   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_dvd   <= w_dvd_nxt;
            r_bmag  <= w_bmag_nxt;
            r_sb    <= w_sb_nxt;
            r_a     <= w_a_nxt;
            r_quo   <= w_quo_nxt;
            r_mod   <= w_mod_nxt;
            r_dbz   <= w_dbz_nxt;
        end
    end

    // Decoded straight from the state register: no input-to-output path.
    assign bus.BUSY        = (r_state != StIdle);
    assign bus.DONE        = (r_state == StDone);
    assign bus.A_DIV_B     = r_quo;
    assign bus.A_MOD_B     = r_mod;
    assign bus.DIV_BY_ZERO = r_dbz;

endmodule

// File: tb/tb_si_div.sv
// tb_si_div: directed test of si_div (N=8) against an arithmetic reference
// model plus hand-computed literal results.
module tb_si_div;
    localparam int unsigned N = 8;
    localparam int unsigned M = N - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    si_div_if #(.N(N)) bus ();

    si_div #(.N(N)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {dbz, quotient, remainder} from plain integer arithmetic.
    function automatic logic [2*N:0] f_expect(input logic [N-1:0] a, input logic [N-1:0] b);
        int unsigned am, bm;
        logic sa, sb, sq, sr;
        logic [N-1:0] q, r;
        am = a[M-1:0];
        bm = b[M-1:0];
        sa = a[N-1];
        sb = b[N-1];
        if (bm == 0) begin
            sq = sa ^ sb;
`ifdef SI_DIV_ZERO_NORM_EN
            sr = sa & (am != 0);
`else
            sr = sa;
`endif
            q = {sq, {M{1'b1}}};
            r = {sr, a[M-1:0]};
            return {1'b1, q, r};
        end
        sq = sa ^ sb;
        sr = sa;
`ifdef SI_DIV_ZERO_NORM_EN
        if (am / bm == 0) sq = 1'b0;
        if (am % bm == 0) sr = 1'b0;
`endif
        q = {sq, M'(am / bm)};
        r = {sr, M'(am % bm)};
        return {1'b0, q, r};
    endfunction

    // Transaction-level model: latency counter plus expected visible outputs.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_left = 0;
    logic [N-1:0] m_quo  = '0;
    logic [N-1:0] m_mod  = '0;
    logic         m_dbz  = 1'b0;
    logic [2*N:0] m_pend = '0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_quo  <= '0;
            m_mod  <= '0;
            m_dbz  <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_done <= 1'b1;
                {m_dbz, m_quo, m_mod} <= m_pend;
            end
            m_left <= m_left - 1;
        end else if (bus.START) begin
            m_busy <= 1'b1;
            m_dbz  <= 1'b0;
            m_pend <= f_expect(bus.A, bus.B);
            m_left <= (bus.B[M-1:0] == '0) ? 1 : int'(N - 1);
        end
    end

    always @(negedge CLK) begin
        chk("busy", 32'(bus.BUSY), 32'(m_busy));
        chk("done", 32'(bus.DONE), 32'(m_done));
        chk("div_by_zero", 32'(bus.DIV_BY_ZERO), 32'(m_dbz));
        chk("a_div_b", 32'(bus.A_DIV_B), 32'(m_quo));
        chk("a_mod_b", 32'(bus.A_MOD_B), 32'(m_mod));
    end

    // One operation with literal expectations; returns in the first idle cycle.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] em,
                          input logic edbz, input int elat);
        int k;
        bit seen;
        @(negedge CLK);
        bus.START = 1'b1;
        bus.A     = a;
        bus.B     = b;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge CLK);
            k++;
            bus.START = 1'b0;
            bus.A     = ~a;   // later operand changes must not matter
            bus.B     = ~b;
            if (bus.DONE) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(k - 1), 32'(elat));
        chk("lit_quo", 32'(bus.A_DIV_B), 32'(eq));
        chk("lit_mod", 32'(bus.A_MOD_B), 32'(em));
        chk("lit_dbz", 32'(bus.DIV_BY_ZERO), 32'(edbz));
    endtask

    logic [N-1:0] mod_neg127, quo_neg3, quo_zero;
    int dones;

    initial begin
`ifdef SI_DIV_ZERO_NORM_EN
        mod_neg127 = 8'h00;
        quo_neg3   = 8'h00;
        quo_zero   = 8'h00;
`else
        mod_neg127 = 8'h80;
        quo_neg3   = 8'h80;
        quo_zero   = 8'h80;
`endif
        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_quo", 32'(bus.A_DIV_B), 32'd0);

        run_op(8'h0D, 8'h84, 8'h83, 8'h01, 1'b0, 7);
        run_op(8'hFF, 8'h81, 8'h7F, mod_neg127, 1'b0, 7);
        run_op(8'h05, 8'h80, 8'hFF, 8'h05, 1'b1, 1);
        run_op(8'h0C, 8'h03, 8'h04, 8'h00, 1'b0, 7);
        run_op(8'h83, 8'h05, quo_neg3, 8'h83, 1'b0, 7);
        run_op(8'h7F, 8'h02, 8'h3F, 8'h01, 1'b0, 7);
        run_op(8'h00, 8'h85, quo_zero, 8'h00, 1'b0, 7);
        run_op(8'h85, 8'h00, 8'hFF, 8'h85, 1'b1, 1);
        run_op(8'h7F, 8'h7F, 8'h01, 8'h00, 1'b0, 7);
        run_op(8'hC8, 8'h0A, 8'h87, 8'h82, 1'b0, 7);

        // Extra START pulses: one sampled mid-CALC, one sampled in the DONE cycle.
        @(negedge CLK);
        bus.START = 1'b1;
        bus.A     = 8'h0D;
        bus.B     = 8'h84;
        dones     = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            if (bus.DONE) dones++;
            bus.START = (k == 3 || k == 8);
            bus.A     = 8'h7F;
            bus.B     = 8'h01;
        end
        chk("ignored_start_dones", 32'(dones), 32'd1);
        chk("ignored_start_quo", 32'(bus.A_DIV_B), 32'h83);
        chk("ignored_start_busy", 32'(bus.BUSY), 32'd0);

        // Reset in the middle of CALC.
        @(negedge CLK);
        bus.START = 1'b1;
        bus.A     = 8'h7F;
        bus.B     = 8'h03;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            bus.START = 1'b0;
        end
        #2 RST = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.BUSY), 32'd0);
        chk("abort_done", 32'(bus.DONE), 32'd0);
        chk("abort_quo", 32'(bus.A_DIV_B), 32'd0);
        chk("abort_mod", 32'(bus.A_MOD_B), 32'd0);
        repeat (2) @(negedge CLK);
        RST   = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (bus.DONE) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        run_op(8'h0D, 8'h84, 8'h83, 8'h01, 1'b0, 7);

        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
